// File: rtl/serdes_align_pkg.sv
// serdes_align_pkg
//   Shared types and helpers for the ISERDES word aligner.
//   - align_state_t         : aligner FSM state encoding
//   - DEFAULT_TRAIN_PATTERN : training word the link sends while aligning
//   - mask_word(width)      : 8-bit mask with the low 'width' bits set
package serdes_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } align_state_t;

  localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'hB4;

  // Width is expected in 1..8; training words are at most one byte wide.
  function automatic logic [7:0] mask_word(input int unsigned width);
    logic [7:0] ones;
    ones = 8'hFF;
    return ones >> (8 - width);
  endfunction

endpackage

// File: rtl/serdes_word_aligner.sv
// serdes_word_aligner
//   Drives ISERDES BITSLIP until the deserialised word matches the training
//   pattern for LOCK_COUNT consecutive cycles, then flags lock and marks the
//   registered word stream as valid user data.
//
//   Ports:
//     clk        in   CLKDIV-domain clock
//     rst        in   synchronous, active-high reset
//     en         in   1 = run/hold alignment, 0 = return to idle
//     din        in   ISERDES parallel word, valid every cycle
//     bitslip    out  one-cycle pulse to ISERDES BITSLIP
//     locked     out  alignment achieved
//     error      out  MAX_SLIPS exhausted without lock
//     slip_cnt   out  slips issued since leaving idle (saturating)
//     dout       out  din delayed by one cycle
//     dout_valid out  dout is aligned user data
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | disabled; status outputs and counters cleared
//   ST_CHECK  | comparing din against the training word
//   ST_SLIP   | bitslip pulse issued this cycle
//   ST_WAIT   | din ignored while ISERDES settles on the new phase
//   ST_LOCKED | aligned; data forwarded as valid until en drops
//   ST_FAIL   | all slips exhausted; error held until en drops
module serdes_word_aligner
  import serdes_align_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter logic [7:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int         LOCK_COUNT    = 16,
  parameter int         SLIP_WAIT     = 4,
  parameter int         MAX_SLIPS     = 2 * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic                         bitslip,
  output logic                         locked,
  output logic                         error,
  output logic [$clog2(MAX_SLIPS+1)-1:0] slip_cnt,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         dout_valid
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);

  align_state_t        state;
  align_state_t        state_nx;
  logic [MATCH_W-1:0]  match_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [7:0]          din_ext;
  logic                din_match;
  logic                slips_done;

  assign din_ext    = 8'(din);
  assign din_match  = ((din_ext ^ TRAIN_PATTERN) & mask_word(DATA_WIDTH)) == 8'h00;
  assign slips_done = (slip_cnt == SLIP_W'(MAX_SLIPS));

  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_nx = ST_CHECK;
        ST_CHECK: begin
          if (din_match) begin
            if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) state_nx = ST_LOCKED;
          end else if (slips_done) begin
            state_nx = ST_FAIL;
          end else begin
            state_nx = ST_SLIP;
          end
        end
        ST_SLIP:   state_nx = ST_WAIT;
        // Down-counter loaded with SLIP_WAIT: the last wait cycle is the one
        // that sees the count at 1, so WAIT lasts exactly SLIP_WAIT cycles.
        ST_WAIT:   if (wait_cnt == WAIT_W'(1)) state_nx = ST_CHECK;
        ST_LOCKED: state_nx = ST_LOCKED;
        ST_FAIL:   state_nx = ST_FAIL;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      match_cnt  <= '0;
      wait_cnt   <= '0;
      slip_cnt   <= '0;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      error      <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      state <= state_nx;
      dout  <= din;

      // Status flags are decoded from the next state so they line up with
      // the state register (bitslip is high during the SLIP cycle itself).
      bitslip    <= (state_nx == ST_SLIP);
      locked     <= (state_nx == ST_LOCKED);
      dout_valid <= (state_nx == ST_LOCKED);
      error      <= (state_nx == ST_FAIL);

      if (state_nx == ST_IDLE) begin
        match_cnt <= '0;
        wait_cnt  <= '0;
        slip_cnt  <= '0;
      end else begin
        if (state == ST_CHECK) begin
          match_cnt <= din_match ? match_cnt + 1'b1 : '0;
        end
        // Counted on entry to SLIP so slip_cnt already includes the pulse
        // that is on the wire.
        if (state_nx == ST_SLIP && !slips_done) begin
          slip_cnt <= slip_cnt + 1'b1;
        end
        if (state == ST_SLIP) begin
          wait_cnt <= WAIT_W'(SLIP_WAIT);
        end else if (state == ST_WAIT && wait_cnt != '0) begin
          wait_cnt <= wait_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serdes_word_aligner.sv
// Bench for serdes_word_aligner: an 8-bit instance driven by a behavioural
// ISERDES model (one bit of rotation per bitslip, applied two cycles later)
// and a 4-bit instance driven directly.
module tb_serdes_word_aligner;

  localparam logic [7:0] TRAIN     = 8'hB4;
  localparam int         LOCK_N    = 16;
  localparam int         SLIP_WAIT = 4;
  localparam int         ATTEMPT   = 2 + SLIP_WAIT;

  logic       clk;
  logic       rst;
  logic       en8, en4;
  logic [7:0] din8;
  logic [3:0] din4;
  logic       bitslip8, locked8, error8, dout_valid8;
  logic [4:0] slip_cnt8;
  logic [7:0] dout8;
  logic       bitslip4, locked4, error4, dout_valid4;
  logic [3:0] slip_cnt4;
  logic [3:0] dout4;

  int n_err    = 0;
  int n_checks = 0;

  logic [7:0] dq8[$];
  logic [3:0] dq4[$];

  int   cyc       = 0;
  int   phase     = 0;
  bit   model_on  = 0;
  bit   sd1       = 0;
  bit   sd2       = 0;
  int   pulses8   = 0;
  int   pulses4   = 0;
  int   last8     = -1;
  bit   spacing_on = 0;
  logic bs8_prev  = 1'b0;
  logic bs4_prev  = 1'b0;
  int   n;

  serdes_word_aligner dut8 (
    .clk(clk), .rst(rst), .en(en8), .din(din8),
    .bitslip(bitslip8), .locked(locked8), .error(error8),
    .slip_cnt(slip_cnt8), .dout(dout8), .dout_valid(dout_valid8)
  );

  serdes_word_aligner #(.DATA_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .din(din4),
    .bitslip(bitslip4), .locked(locked4), .error(error4),
    .slip_cnt(slip_cnt4), .dout(dout4), .dout_valid(dout_valid4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e8;
    logic [3:0] e4;
    dq8.push_back(rst ? 8'h00 : din8);
    dq4.push_back(rst ? 4'h0 : din4);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e8 = dq8.pop_front();
    e4 = dq4.pop_front();
    check("dout8", 32'(dout8), 32'(e8));
    check("dout4", 32'(dout4), 32'(e4));
    check("bitslip8_single", 32'(bs8_prev & bitslip8), 32'd0);
    check("bitslip4_single", 32'(bs4_prev & bitslip4), 32'd0);
    if (bitslip8) begin
      pulses8++;
      if (spacing_on && last8 >= 0) check("slip_spacing", 32'(cyc - last8), 32'(ATTEMPT));
      last8 = cyc;
    end
    if (bitslip4) pulses4++;
    bs8_prev = bitslip8;
    bs4_prev = bitslip4;
    sd2 = sd1;
    sd1 = bitslip8;
    if (sd2) phase = (phase + 7) % 8;
    if (model_on) din8 = rotl8(TRAIN, phase);
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return locked8;
      1:       return error8;
      2:       return locked4;
      3:       return error4;
      default: return (pulses8 >= 2);
    endcase
  endfunction

  task automatic run_until(input int sel, input int bound, output int cnt);
    cnt = 0;
    while (cnt < bound && !cond(sel)) begin
      tick();
      cnt++;
    end
  endtask

  task automatic start_test8(input int ph, input bit use_model);
    en8 = 1'b0;
    tick();
    pulses8 = 0; last8 = -1; sd1 = 0; sd2 = 0;
    model_on = use_model;
    phase = ph;
    din8 = use_model ? rotl8(TRAIN, ph) : 8'h00;
    en8 = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en8 = 1'b0; en4 = 1'b0; din8 = 8'h00; din4 = 4'h0;
    tick();
    tick();
    check("rst_bitslip", 32'(bitslip8), 32'd0);
    check("rst_locked", 32'(locked8), 32'd0);
    check("rst_error", 32'(error8), 32'd0);
    check("rst_slip_cnt", 32'(slip_cnt8), 32'd0);
    check("rst_dout_valid", 32'(dout_valid8), 32'd0);
    check("rst_locked4", 32'(locked4), 32'd0);
    rst = 1'b0;

    // pre-aligned stream
    start_test8(0, 1);
    run_until(0, 200, n);
    check("t1_lock_cycle", 32'(n), 32'(LOCK_N + 1));
    check("t1_dout_valid", 32'(dout_valid8), 32'd1);
    check("t1_slip_cnt", 32'(slip_cnt8), 32'd0);
    check("t1_pulses", 32'(pulses8), 32'd0);
    check("t1_dout", 32'(dout8), 32'(TRAIN));

    // three bits off
    spacing_on = 1;
    start_test8(3, 1);
    check("t2_drop_locked", 32'(locked8), 32'd0);
    check("t2_drop_valid", 32'(dout_valid8), 32'd0);
    check("t2_drop_slip_cnt", 32'(slip_cnt8), 32'd0);
    check("t2_drop_error", 32'(error8), 32'd0);
    run_until(0, 300, n);
    check("t2_lock_cycle", 32'(n), 32'(1 + 3 * ATTEMPT + LOCK_N));
    check("t2_pulses", 32'(pulses8), 32'd3);
    check("t2_slip_cnt", 32'(slip_cnt8), 32'd3);
    check("t2_dout_valid", 32'(dout_valid8), 32'd1);

    // never aligns
    start_test8(0, 0);
    run_until(1, 400, n);
    check("t3_error_cycle", 32'(n), 32'(1 + 16 * ATTEMPT + 1));
    check("t3_pulses", 32'(pulses8), 32'd16);
    check("t3_slip_cnt", 32'(slip_cnt8), 32'd16);
    check("t3_locked", 32'(locked8), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("t3_hold_error", 32'(error8), 32'd1);
    check("t3_hold_slip_cnt", 32'(slip_cnt8), 32'd16);
    check("t3_hold_pulses", 32'(pulses8), 32'd16);
    en8 = 1'b0;
    tick();
    check("t3_abort_error", 32'(error8), 32'd0);
    check("t3_abort_slip_cnt", 32'(slip_cnt8), 32'd0);
    check("t3_abort_bitslip", 32'(bitslip8), 32'd0);
    spacing_on = 0;

    // 10 matches, one slipped word, then aligned again
    start_test8(0, 1);
    for (int i = 0; i < 11; i++) tick();
    check("t4_no_early_lock", 32'(locked8), 32'd0);
    phase = 1;
    din8 = rotl8(TRAIN, 1);
    run_until(0, 200, n);
    check("t4_lock_cycle", 32'(n), 32'(ATTEMPT + LOCK_N));
    check("t4_slip_cnt", 32'(slip_cnt8), 32'd1);

    // reset during WAIT after the second slip
    start_test8(3, 1);
    run_until(4, 100, n);
    check("t5_two_pulses", 32'(pulses8), 32'd2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5_rst_bitslip", 32'(bitslip8), 32'd0);
    check("t5_rst_slip_cnt", 32'(slip_cnt8), 32'd0);
    check("t5_rst_locked", 32'(locked8), 32'd0);
    check("t5_rst_error", 32'(error8), 32'd0);
    check("t5_rst_dout", 32'(dout8), 32'd0);
    rst = 1'b0;
    last8 = -1;
    run_until(0, 200, n);
    check("t5_lock_cycle", 32'(n), 32'(1 + ATTEMPT + LOCK_N));
    check("t5_slip_cnt", 32'(slip_cnt8), 32'd1);
    en8 = 1'b0;
    model_on = 0;
    tick();

    // 4-bit instance: only the low nibble of the training word matters
    din4 = 4'h4;
    en4 = 1'b1;
    run_until(2, 200, n);
    check("t6_lock_cycle", 32'(n), 32'(LOCK_N + 1));
    check("t6_slip_cnt", 32'(slip_cnt4), 32'd0);
    check("t6_dout", 32'(dout4), 32'h4);
    en4 = 1'b0;
    tick();
    check("t6_abort_locked", 32'(locked4), 32'd0);
    pulses4 = 0;
    din4 = 4'hB;
    en4 = 1'b1;
    run_until(3, 300, n);
    check("t6_error_cycle", 32'(n), 32'(1 + 8 * ATTEMPT + 1));
    check("t6_pulses", 32'(pulses4), 32'd8);
    check("t6_slip_cnt", 32'(slip_cnt4), 32'd8);
    check("t6_locked", 32'(locked4), 32'd0);
    en4 = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/serdes_word_aligner.md
# serdes_word_aligner

Word-alignment controller that sits directly downstream of the ISERDES receive path in the serdes loopback test. It consumes the deserialised parallel word on the CLKDIV domain and pulses BITSLIP until a known training pattern is seen for a run of consecutive cycles. It then declares lock and forwards aligned words to the checker logic.

## Interface

Parameters:
- DATA_WIDTH, 8, parallel word width (2..8)
- TRAIN_PATTERN, 8'hB4, training word; only the low DATA_WIDTH bits are compared
- LOCK_COUNT, 16, consecutive matches required for lock (≥1)
- SLIP_WAIT, 4, cycles ignored after each bitslip pulse (≥1)
- MAX_SLIPS, 2*DATA_WIDTH, slips attempted before declaring failure

Ports:
- clk, in, 1: CLKDIV-domain clock
- rst, in, 1: reset, synchronous, active-high
- en, in, 1: level; 1 = run/hold alignment, 0 = return to IDLE
- din, in, DATA_WIDTH: ISERDES parallel output, valid every cycle
- bitslip, out, 1: one-cycle pulse to ISERDES BITSLIP
- locked, out, 1: alignment achieved
- error, out, 1: MAX_SLIPS exhausted without lock
- slip_cnt, out, $clog2(MAX_SLIPS+1): slips issued since leaving IDLE
- dout, out, DATA_WIDTH: registered din
- dout_valid, out, 1: dout is aligned user data

## Operation

- Reset values: state IDLE; bitslip, locked, error, dout_valid = 0; slip_cnt = 0; dout = 0; match and wait counters = 0.
- IDLE: all status outputs 0, counters cleared; en=1 → CHECK.
- CHECK: compare din to TRAIN_PATTERN masked to DATA_WIDTH bits.
  - On match: match_cnt++. When the match brings match_cnt to LOCK_COUNT → LOCKED.
  - On mismatch: match_cnt=0. If slip_cnt == MAX_SLIPS → FAIL, else → SLIP.
- SLIP: bitslip=1 for exactly this cycle; slip_cnt++; load wait_cnt=SLIP_WAIT → WAIT.
- WAIT: din ignored; wait_cnt-- each cycle; at 0 → CHECK.
- LOCKED: locked=1, dout_valid=1; stays until en=0 or rst. No loss-of-lock detection (user data follows).
- FAIL: error=1, locked=0; stays until en=0 or rst.
- en=0 in any state → IDLE next cycle; the abort takes priority over every other transition.
- slip_cnt saturates at MAX_SLIPS and never wraps.
- bitslip is never high on two consecutive cycles.

## Timing

- dout <= din every cycle, so dout has 1-cycle latency in all states.
- dout_valid and locked are registered from next-state == LOCKED. Both rise the cycle after the final matching din, and on that cycle dout = TRAIN_PATTERN.
- en sampled high at cycle 0 → CHECK at cycle 1. All-matching din from cycle 1 → locked=1 at cycle LOCK_COUNT+1.
- Slip cost per failed alignment attempt: 1 mismatch cycle, then 1 SLIP cycle, then SLIP_WAIT WAIT cycles, then CHECK. Total 2+SLIP_WAIT cycles between successive CHECK entries.
- rst mid-operation: all outputs return to reset values on the next edge. Any in-flight bitslip is dropped.
- en falling while LOCKED: locked, dout_valid, slip_cnt, error all 0 the next cycle.

## Structure

- Package serdes_align_pkg holds:
  - state enum {IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL}
  - default TRAIN_PATTERN constant
  - mask_word(width) function, shared with the top-level MASK logic
- Single module; FSM plus three counters (match, wait, slip) inline. No sub-module needed.
- The bench provides a behavioural ISERDES model: the serial pattern is rotated by one bit per bitslip pulse, and the new phase takes effect 2 cycles after the pulse.

## Test plan

1. Pre-aligned: en=1, din=8'hB4 constant → no bitslip pulses; locked=1 and dout_valid=1 at cycle 17; slip_cnt=0; dout=8'hB4.
2. Three-slip alignment: model starts 3 bits off → exactly 3 single-cycle bitslip pulses, spaced 6 cycles apart; slip_cnt=3; locked asserted after 16 further matches.
3. Never aligns: din=8'h00 constant → 16 pulses, then error=1, locked=0, slip_cnt=16 holding; a further en=0 for one cycle returns all outputs to 0.
4. Interrupted run: 10 matches, 1 mismatch, then aligned → match counter restarts; lock arrives 16 matches after the mismatch's realignment, not before.
5. Reset mid-WAIT: rst pulsed during WAIT after slip 2 → next cycle all outputs 0, state IDLE; a clean realign follows once en is held high.
6. DATA_WIDTH=4, TRAIN_PATTERN=8'hB4: compare uses only 4'h4; din upper bits are ignored; at most 8 slips before error.
